// File: rtl/routing_rr_sel_4.sv
// Round-robin select sequencer for four requesters driving a 4:1 mux select.
// Optional ROUTING_RR_LOCK_EN adds a lock input that suspends the forced beat-limit rotation.
module routing_rr_sel_4 #(
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic             ack,
`ifdef ROUTING_RR_LOCK_EN
    input  logic             lock,
`endif
    output logic [1:0]       sel,
    output logic [3:0]       gnt,
    output logic             valid,
    output logic [CNT_W-1:0] beat
);

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [1:0]       sel_n;
    logic [3:0]       gnt_n;
    logic             valid_n;
    logic [CNT_W-1:0] beat_n;
    logic             hold_max;
    logic             rel;
    logic [2:0]       pick;

    // Returns {found, index} of the first set request scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = 2'(start + 2'(k));
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef ROUTING_RR_LOCK_EN
    assign hold_max = lock;
`else
    assign hold_max = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        gnt_n   = gnt;
        valid_n = valid;
        beat_n  = beat;
        rel     = 1'b0;
        pick    = 3'b000;
        case (state)
            IDLE: begin
                gnt_n   = 4'b0000;
                valid_n = 1'b0;
                beat_n  = '0;
                pick    = rr_pick(req, ptr);
                if (pick[2]) begin
                    state_n = GRANT;
                    sel_n   = pick[1:0];
                    gnt_n   = 4'(4'b0001 << pick[1:0]);
                    valid_n = 1'b1;
                end
            end
            GRANT: begin
                rel = !req[sel] || (ack && (beat == BEAT_LAST) && !hold_max);
                if (rel) begin
                    ptr_n  = 2'(sel + 2'd1);
                    beat_n = '0;
                    // Current owner rescanned last so it only wins when alone.
                    pick   = rr_pick(req, 2'(sel + 2'd1));
                    if (pick[2]) begin
                        sel_n   = pick[1:0];
                        gnt_n   = 4'(4'b0001 << pick[1:0]);
                        valid_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'b0000;
                        valid_n = 1'b0;
                    end
                end else if (ack && (beat != BEAT_LAST)) begin
                    beat_n = CNT_W'(beat + 1'b1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                valid_n = 1'b0;
                beat_n  = '0;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            gnt   <= 4'b0000;
            valid <= 1'b0;
            beat  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            gnt   <= gnt_n;
            valid <= valid_n;
            beat  <= beat_n;
        end
    end

endmodule
